// File: rtl/piano_pkg.sv
// piano_pkg
//   Shared constants and types for the note sequencer slice.
//   NOTE_W_DEF     : default key/note code width (one bit per key)
//   DEPTH          : number of note slots in the sequence memory
//   CNT_W          : width of the slot index
//   TONE_TICKS_DEF : default hold time of one recorded note, in clocks
//   REST           : note code that means "no key / silence"
//   play_state_t   : playback engine state
//   next_slot()    : modulo-DEPTH slot increment
package piano_pkg;

  localparam int NOTE_W_DEF     = 8;
  localparam int DEPTH          = 8;
  localparam int CNT_W          = 3;
  localparam int TONE_TICKS_DEF = 1000;

  localparam logic [NOTE_W_DEF-1:0] REST = '0;

  typedef enum logic {
    PLAY_IDLE = 1'b0,
    PLAY_RUN  = 1'b1
  } play_state_t;

  // DEPTH is a power of two, so the natural 3-bit wrap is the slot wrap.
  function automatic logic [CNT_W-1:0] next_slot(input logic [CNT_W-1:0] slot);
    return slot + 1'b1;
  endfunction

endpackage

// File: rtl/key_edge_det.sv
// key_edge_det
//   Registers the (already debounced, synchronous) key levels, detects a
//   press from silence and latches the pressed code for later recording.
//   clock    : system clock
//   reset    : asynchronous, active-high
//   keys     : key levels
//   suppress : forces chk low (playback running)
//   keys_q   : keys registered once
//   chk      : one-cycle pulse on a press from all-keys-released
//   captured : code held at the most recent press
module key_edge_det
  import piano_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NOTE_W-1:0] keys,
  input  logic              suppress,
  output logic [NOTE_W-1:0] keys_q,
  output logic              chk,
  output logic [NOTE_W-1:0] captured
);

  logic [NOTE_W-1:0] keys_prev;
  logic              press;

  // A press is only recognised out of silence; adding a second key while
  // one is held does not count as a new note.
  assign press = (keys_q != '0) && (keys_prev == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keys_q    <= '0;
      keys_prev <= '0;
      chk       <= 1'b0;
      captured  <= '0;
    end else begin
      keys_q    <= keys;
      keys_prev <= keys_q;
      chk       <= press && !suppress;
      if (press) begin
        captured <= keys_q;
      end
    end
  end

endmodule

// File: rtl/note_seq_mem.sv
// note_seq_mem
//   Eight-slot note store with slot counter, key-press detector and timed
//   playback engine, sitting between the record/playback control FSM and
//   the tone generator.
//   clock       : system clock
//   reset       : asynchronous, active-high; clears memory too
//   clr         : synchronous session clear (cnt, tick, playback flag)
//   ce          : slot enable from the control FSM
//   RW          : 1 = record, 0 = play
//   keys        : key levels, synchronous to clock
//   cnt         : current slot index
//   chk         : one-cycle key-press pulse
//   note_out    : code for the tone generator
//   play_active : playback engine running
module note_seq_mem
  import piano_pkg::*;
#(
  parameter int NOTE_W     = NOTE_W_DEF,
  parameter int TONE_TICKS = TONE_TICKS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              ce,
  input  logic              RW,
  input  logic [NOTE_W-1:0] keys,
  output logic [CNT_W-1:0]  cnt,
  output logic              chk,
  output logic [NOTE_W-1:0] note_out,
  output logic              play_active
);

  localparam int TICK_W = $clog2(TONE_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TONE_TICKS - 1);

  play_state_t       state;
  play_state_t       next_state;
  logic [TICK_W-1:0] tick;
  logic              tick_last;
  logic              play_req;
  logic              write_en;
  logic              advance;
  logic [NOTE_W-1:0] keys_q;
  logic [NOTE_W-1:0] captured;
  logic [NOTE_W-1:0] mem [DEPTH];

  key_edge_det #(
    .NOTE_W(NOTE_W)
  ) u_key_edge_det (
    .clock   (clock),
    .reset   (reset),
    .keys    (keys),
    .suppress(play_active),
    .keys_q  (keys_q),
    .chk     (chk),
    .captured(captured)
  );

  assign play_req  = ce && !RW;
  assign tick_last = (tick == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= PLAY_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The play request is only re-sampled at the end of a note, so a note
  // that has started always plays for its full hold time.
  always_comb begin
    next_state = state;
    case (state)
      PLAY_IDLE: begin
        if (!clr && play_req) begin
          next_state = PLAY_RUN;
        end
      end
      PLAY_RUN: begin
        if (clr) begin
          next_state = PLAY_IDLE;
        end else if (tick_last && !play_req) begin
          next_state = PLAY_IDLE;
        end
      end
      default: next_state = PLAY_IDLE;
    endcase
  end

  // Record writes are locked out while the engine runs.
  always_comb begin
    play_active = (state == PLAY_RUN);
    write_en    = !clr && !play_active && ce && RW;
    advance     = !clr && play_active && tick_last;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (clr || !play_active || tick_last) begin
      tick <= '0;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (advance || write_en) begin
      cnt <= next_slot(cnt);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[cnt] <= captured;
    end
  end

  // One cycle behind the engine state, so a clear takes the output back
  // to live keys on the edge after the clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      note_out <= NOTE_W'(REST);
    end else if (play_active) begin
      note_out <= mem[cnt];
    end else begin
      note_out <= keys_q;
    end
  end

endmodule

// File: tb/tb_note_seq_mem.sv
// tb_note_seq_mem
//   Directed bench for note_seq_mem with a short note hold (4 clocks).
//   Inputs are driven just after the falling edge and outputs are sampled
//   at the falling edge, half a period after the rising edge that set them.
module tb_note_seq_mem;

  logic       clock = 1'b0;
  logic       reset;
  logic       clr;
  logic       ce;
  logic       RW;
  logic [7:0] keys;
  logic [2:0] cnt;
  logic       chk;
  logic [7:0] note_out;
  logic       play_active;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  note_seq_mem #(
    .NOTE_W    (8),
    .TONE_TICKS(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clr        (clr),
    .ce         (ce),
    .RW         (RW),
    .keys       (keys),
    .cnt        (cnt),
    .chk        (chk),
    .note_out   (note_out),
    .play_active(play_active)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic rw, input logic cl,
                               input logic [7:0] k);
    ce   = c;
    RW   = rw;
    clr  = cl;
    keys = k;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    checkOutput("reset_cnt", 32'(cnt), 32'd0);
    checkOutput("reset_chk", 32'(chk), 32'd0);
    checkOutput("reset_note_out", 32'(note_out), 32'd0);
    checkOutput("reset_play_active", 32'(play_active), 32'd0);
    reset = 1'b0;
    step();

    // Key press: pulse two edges after the rise, none while held or widened.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h04);
    step();
    checkOutput("key_chk_edge1", 32'(chk), 32'd0);
    step();
    checkOutput("key_chk_edge2", 32'(chk), 32'd1);
    checkOutput("key_live_note", 32'(note_out), 32'h04);
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("key_chk_held", 32'(chk), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h0C);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("key_chk_widen", 32'(chk), 32'd0);
    end
    checkOutput("key_live_widen", 32'(note_out), 32'h0C);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();

    // Record 1<<i into slot i.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'(1 << i));
      step();
      step();
      checkOutput("rec_chk", 32'(chk), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'(1 << i));
      step();
      checkOutput("rec_cnt", 32'(cnt), 32'((i + 1) % 8));
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      step();
      step();
    end

    // Full playback, ce dropped once slot 7 is reached.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("play_start", 32'(play_active), 32'd1);
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        checkOutput("play_note", 32'(note_out), 32'(1 << s));
        if (k == 0) begin
          checkOutput("play_cnt", 32'(cnt), 32'(s));
          if (s == 7) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
          end
        end
        checkOutput("play_chk_quiet", 32'(chk), 32'd0);
      end
    end
    checkOutput("play_end_active", 32'(play_active), 32'd0);
    checkOutput("play_end_cnt", 32'(cnt), 32'd0);
    step();
    checkOutput("play_end_live", 32'(note_out), 32'h00);

    // Tail: ce dropped one cycle into slot 2.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("tail_start", 32'(play_active), 32'd1);
    for (int j = 0; j < 8; j++) begin
      step();
    end
    checkOutput("tail_cnt_slot2", 32'(cnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("tail_note_a", 32'(note_out), 32'h04);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h20);
    step();
    checkOutput("tail_note_b", 32'(note_out), 32'h04);
    step();
    checkOutput("tail_note_c", 32'(note_out), 32'h04);
    checkOutput("tail_chk_suppressed", 32'(chk), 32'd0);
    step();
    checkOutput("tail_note_d", 32'(note_out), 32'h04);
    checkOutput("tail_cnt", 32'(cnt), 32'd3);
    checkOutput("tail_stopped", 32'(play_active), 32'd0);
    step();
    checkOutput("tail_live", 32'(note_out), 32'h20);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    step();

    // Write strobe during playback is ignored; then clr at tick 2.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    checkOutput("wip_note_before", 32'(note_out), 32'h08);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("wip_cnt", 32'(cnt), 32'd3);
    checkOutput("wip_active", 32'(play_active), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("wip_mem_kept", 32'(note_out), 32'h08);
    step();
    checkOutput("wip_cnt_next", 32'(cnt), 32'd4);
    step();
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    checkOutput("clr_cnt", 32'(cnt), 32'd0);
    checkOutput("clr_active", 32'(play_active), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    checkOutput("clr_live", 32'(note_out), 32'h00);

    // Asynchronous reset mid-playback, then memory must read back empty.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    step();
    checkOutput("rst_pre_note", 32'(note_out), 32'h01);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_cnt", 32'(cnt), 32'd0);
    checkOutput("rst_async_chk", 32'(chk), 32'd0);
    checkOutput("rst_async_note", 32'(note_out), 32'd0);
    checkOutput("rst_async_active", 32'(play_active), 32'd0);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h40);
    step();
    step();
    checkOutput("rst_mem_active", 32'(play_active), 32'd1);
    checkOutput("rst_mem_slot0", 32'(note_out), 32'h00);
    for (int j = 0; j < 4; j++) begin
      step();
    end
    checkOutput("rst_mem_slot1", 32'(note_out), 32'h00);
    checkOutput("rst_mem_cnt", 32'(cnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
